// File: rtl/mc_controller.sv
// Control unit for the multicycle ARM datapath. It contains the main FSM, the ALU decoder,
// the condition check and the NZCV flag register.
// Outputs are combinational from the FSM state, the registered instruction and the flag register.
// With MEM_HANDSHAKE=1, FETCH, MEMREAD and MEMWR stay put until MemReady is high.
//
// Ports: clk, reset (synchronous, active-low); Instr = Instr[31:12] from the datapath IR;
//        ALUFlags = live NZCV; MemReady = memory access complete.
//        Outputs: write enables (PCWrite, RegWrite, MemWrite, IRWrite) and datapath selects
//        (AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl).
module mc_controller #(
    parameter int ALU_CTRL_W    = 2,
    parameter int MEM_HANDSHAKE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [19:0]           Instr,
    input  logic [3:0]            ALUFlags,
    input  logic                  MemReady,
    output logic                  PCWrite,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  AdrSrc,
    output logic [1:0]            RegSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam bit HAS_EOR = (ALU_CTRL_W >= 3);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_ORR = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_EOR = ALU_CTRL_W'(4);

    state_t state, next_state;
    logic [3:0] flags;      // registered N,Z,C,V
    logic       cond_q;     // CondEx as seen during the previous cycle

    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       s_bit;
    logic       unused_rn;

    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign funct = Instr[13:8];
    assign rd    = Instr[3:0];
    assign cmd   = funct[4:1];
    assign s_bit = funct[0];
    assign unused_rn = ^Instr[11:4];

    assign ImmSrc = op;
    assign RegSrc = {(op == 2'b01) & ~funct[0], op == 2'b10};

    // Without the handshake every memory access completes in its own cycle.
    logic mem_ok;
    assign mem_ok = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

    // ALU decoder
    logic [ALU_CTRL_W-1:0] alu_dec;
    logic supported, is_cmp, arith;
    always_comb begin
        alu_dec   = ALU_ADD;
        supported = 1'b1;
        is_cmp    = 1'b0;
        arith     = 1'b0;
        case (cmd)
            4'b0100: begin alu_dec = ALU_ADD; arith = 1'b1; end
            4'b0010: begin alu_dec = ALU_SUB; arith = 1'b1; end
            4'b0000: alu_dec = ALU_AND;
            4'b1100: alu_dec = ALU_ORR;
            4'b1010: begin alu_dec = ALU_SUB; arith = 1'b1; is_cmp = 1'b1; end
            4'b0001: begin
                if (HAS_EOR) alu_dec = ALU_EOR;
                else         supported = 1'b0;
            end
            default: supported = 1'b0;
        endcase
    end

    // Condition check against the registered flags
    logic n_f, z_f, c_f, v_f, cond_ex;
    assign {n_f, z_f, c_f, v_f} = flags;
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    logic in_exec, flag_we;
    assign in_exec = (state == EXECR) || (state == EXECI);
    assign flag_we = in_exec && cond_ex && supported && (s_bit || is_cmp);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= FETCH;
            flags  <= 4'b0000;
            cond_q <= 1'b0;
        end else begin
            state  <= next_state;
            cond_q <= cond_ex;
            if (flag_we) begin
                flags[3:2] <= ALUFlags[3:2];
                if (arith) flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        case (state)
            FETCH: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                if (mem_ok) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                case (op)
                    2'b00:   next_state = funct[5] ? EXECI : EXECR;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                next_state = funct[0] ? MEMREAD : MEMWR;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ok) next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = cond_ex;
                PCWrite    = cond_ex & (rd == 4'hF);
                next_state = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                if (mem_ok) begin
                    MemWrite   = cond_ex;
                    next_state = FETCH;
                end
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_dec;
                next_state = (is_cmp || !supported) ? FETCH : ALUWB;
            end
            ALUWB: begin
                // Flags may have changed at the end of EXEC; the condition that
                // applies is the one evaluated in EXEC, held in cond_q.
                RegWrite   = cond_q;
                PCWrite    = cond_q & (rd == 4'hF);
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10;
                PCWrite    = cond_ex;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
        if (!reset) begin
            next_state = FETCH;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            AdrSrc     = 1'b0;
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            ALUControl = ALU_ADD;
        end
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Parametrised control unit for the multicycle ARM datapath: main state machine, ALU decoder, condition-check logic and NZCV flag register in one block. It drives every control input of `datapath` from the registered instruction and the live ALU flags. Over the baseline controller it adds CMP and optionally EOR, and an optional memory ready handshake that stalls fetch and data access.

## Interface
- ALU_CTRL_W, 2, ALUControl width; 2 = ADD/SUB/AND/ORR, 3 adds EOR (100)
- MEM_HANDSHAKE, 0, 1 = FETCH/MEMREAD/MEMWR wait for MemReady; 0 = MemReady ignored
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- Instr  in  20  Instr[31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  live ALU NZCV [3:0] = N,Z,C,V
- MemReady  in  1  memory access complete this cycle
- PCWrite, RegWrite, MemWrite, IRWrite  out  1 each  gated write enables
- AdrSrc  out  1  0 = PC, 1 = ALUResult register
- RegSrc  out  2  [0] Rn←PC(15) for branch, [1] Rm←Rd for STR
- ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath mux selects
- ALUControl  out  ALU_CTRL_W  ALU operation

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD, IRWrite=1, PCWrite=1 → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD. Op=00 & Funct[5]=0 → EXECR; Op=00 & Funct[5]=1 → EXECI; Op=01 → MEMADR; Op=10 → BRANCH; Op=11 → FETCH (no effect).
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Funct[0]=1 → MEMREAD, else MEMWR.
- MEMREAD: AdrSrc=1, ResultSrc=00 → MEMWB. MEMWB: ResultSrc=01, RegWrite → FETCH.
- MEMWR: AdrSrc=1, MemWrite → FETCH.
- EXECR: ALUSrcA=00, ALUSrcB=00; EXECI: ALUSrcB=01. Decoded op; → ALUWB, or → FETCH when cmd is CMP or unsupported.
- ALUWB: ResultSrc=00, RegWrite → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ADD, PCWrite → FETCH.
- ImmSrc = Op; RegSrc = {Op==01 & ~Funct[0], Op==10}.
- ALU decode (cmd = Funct[4:1]): 0100 ADD=00, 0010 SUB=01, 0000 AND=10, 1100 ORR=11, 1010 CMP=SUB no writeback, 0001 EOR=100 (only ALU_CTRL_W=3). Other cmds: ADD, RegWrite/flags suppressed.
- Condition: CondEx from Cond and flag register: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
- Gating: RegWrite, MemWrite, and PCWrite of BRANCH and of ALUWB/MEMWB with Rd=15 (ResultSrc redirect to PC) require CondEx. FETCH PCWrite/IRWrite ungated.
- Flags: written at end of EXECR/EXECI when CondEx & S (Funct[0]); N,Z always; C,V only for ADD/SUB/CMP. CMP updates flags regardless of S.

## Timing
- reset=0 at edge: state←FETCH, flags←0000. While reset=0 all write enables 0; selects hold FETCH values.
- Latency (MEM_HANDSHAKE=0): B 3, CMP 3, DP 4, STR 4, LDR 5 cycles.
- MEM_HANDSHAKE=1: FETCH, MEMREAD, MEMWR hold while MemReady=0; IRWrite, FETCH PCWrite, MemWrite pulse only in the MemReady=1 cycle; selects stable throughout stall. Each stall cycle adds exactly one cycle.
- Reset mid-instruction: abandoned, no partial writes after the reset edge.
- Flag write and condition check in the same EXEC cycle use pre-update flags.
- Condition failing: state sequence unchanged, only enables suppressed.

## Test plan
- Reset held 2 cycles, released → state FETCH, IRWrite=1, PCWrite=1, flags 0000, zero enables during reset.
- ADDS R1 (Cond=1110, Op=00, Funct=001001), ALUFlags=0100 in EXECR → 4-cycle sequence, RegWrite in cycle 4, flags=0100.
- CMP then BEQ (Cond=0000) with ALUFlags=0100 → CMP 3 cycles no RegWrite; branch PCWrite=1 cycle 3. Repeat with ALUFlags=0000 → PCWrite=0.
- LDR with MEM_HANDSHAKE=1, MemReady low 3 cycles in MEMREAD → LDR takes 8 cycles, RegWrite exactly once in MEMWB.
- STR with Cond=0001, Z=1 → MemWrite never asserted, returns to FETCH after 4 cycles.
- ALU_CTRL_W=3, EOR (cmd 0001) → ALUControl=100; ALU_CTRL_W=2 same instr → no RegWrite.
